dpa_req_scheduler: RTL and testbench
====================================

// Module: dpa_req_scheduler
// PURPOSE
//  Shares one combinational add/sub datapath (opcodes ADD_U, TC_SUM, SUB_U; sum + cout/neg/ovf/zero) among
//  NUM_REQ requesters. Round-robin arbitration, registered operand issue, registered result/flag capture.
//  Valid/ready handshake on the request and response sides.
//  Sits between requesting engines and the datapath; one operation in flight at a time.
// PARAMETERS
//  WIDTH    32  operand/result width
//  OP_LEN   5   opcode width
//  NUM_REQ  4   number of requesters (>=2); ID_W = $clog2(NUM_REQ) localparam
// PORTS
//  clk          in   1               single clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  req_valid    in   NUM_REQ         per-requester request valid
//  req_ready    out  NUM_REQ         per-requester accept, one-hot or zero
//  req_a        in   NUM_REQ*WIDTH   flattened operand a; slice i = requester i
//  req_b        in   NUM_REQ*WIDTH   flattened operand b
//  req_opcode   in   NUM_REQ*OP_LEN  flattened opcode
//  dp_a         out  WIDTH           registered operand to datapath
//  dp_b         out  WIDTH           registered operand to datapath
//  dp_opcode    out  OP_LEN          registered opcode to datapath
//  dp_sum       in   WIDTH           datapath result
//  dp_cout      in   1               datapath carry out
//  dp_neg       in   1               datapath negative flag
//  dp_ovf       in   1               datapath overflow flag
//  dp_zero      in   1               datapath zero flag
//  rsp_valid    out  1               response valid
//  rsp_ready    in   1               response consumer ready
//  rsp_id       out  ID_W            index of the requester that owns the response
//  rsp_sum      out  WIDTH           captured result
//  rsp_flags    out  4               {cout,neg,ovf,zero}, captured
//  rsp_err      out  1               illegal opcode (macro only)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = 0.
//  FSM states:
//   IDLE
//    - Any req_valid: grant g = first valid at or after the pointer (wrap-around); req_ready[g] = 1 combinationally.
//    - Register dp_a/dp_b/dp_opcode and id; go to EXEC.
//    - Pointer becomes (g+1) mod NUM_REQ.
//   EXEC
//    - Datapath settles on the registered operands.
//    - Capture dp_sum and flags into the rsp_* registers; go to RESP.
//   RESP
//    - rsp_valid = 1; rsp_* held stable until rsp_ready.
//    - On rsp_valid & rsp_ready with a req_valid present: grant in the same cycle (as in IDLE) and go to EXEC.
//    - On rsp_valid & rsp_ready with no req_valid: go to IDLE.
//  Latency: accept edge -> rsp_valid after 2 clk. Peak throughput: 1 op per 2 clk.
//  Handshake rules:
//   - req_ready is only asserted in IDLE, or in RESP while rsp_ready = 1.
//   - A requester must hold its slice stable while req_valid & !req_ready.
//   - req_ready never asserts for a slice with req_valid = 0.
//  dp_* outputs hold their last value when idle (no toggling).
//  rsp_valid deasserts the cycle after the handshake unless a new op completes.
//  No arithmetic in this block: results and flags pass through bit-exact.
//  Reset mid-operation: the in-flight op is dropped, with no response. Outputs clear immediately (asynchronous).
// CONFIGURATION
//  Macro: DPA_OPCODE_CHECK_EN
//  Defined:
//   - Legal opcodes are 5'b00001, 5'b00010 and 5'b00011.
//   - An illegal opcode is accepted but dp_opcode is not updated.
//   - EXEC captures rsp_sum = 0, rsp_flags = 0, rsp_err = 1. Timing is identical to a legal op.
//  Undefined: opcode passed through unchecked; rsp_err tied 0.
// STRUCTURE
//  Package dpa_pkg:
//   - OP_ADD_U = 5'b00001, OP_TC_SUM = 5'b00010, OP_SUB_U = 5'b00011
//   - FSM state encoding IDLE/EXEC/RESP
//   - flag bit indices
//  Sub-module dpa_rr_arbiter(req, ptr -> grant one-hot, grant_idx): purely combinational, reused elsewhere.
//  Top: FSM, pointer register, operand/response registers.
// TESTING
//  Bench instantiates the existing datapath top with WIDTH=32, OP_LEN=5.
//  1. req0 a=7 b=2 op=00001 -> req_ready[0] same cycle; 2 clk later rsp_valid, rsp_id=0, rsp_sum=9, flags=0000.
//  2. All 4 valid, SUB_U a=7 b=2 -> grant order 0,1,2,3 (pointer wraps to 0); each rsp_sum=5, cout=1.
//  3. a=-7 b=-2 ADD_U -> rsp_sum=FFFFFFF7, cout=1, neg=1. a=7 b=2 TC_SUM -> rsp_sum=FFFFFFF7.
//  4. rsp_ready=0 for 5 clk with req1 pending -> rsp_* stable, req_ready=0. rsp_ready=1 -> req1 granted that cycle.
//  5. rst_n low during EXEC -> all outputs 0 asynchronously, no response. After release, requests 2 and 0 valid -> req0 granted first.
//  6. op=5'b11111 -> with DPA_OPCODE_CHECK_EN: rsp_err=1, rsp_sum=0. Without it: rsp_err=0, dp_opcode=11111.

Source files
------------

// File: rtl/dpa_pkg.sv
// Shared definitions for the add/sub datapath scheduler: opcodes, FSM encoding, flag layout.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package dpa_pkg;

   // Datapath opcodes
   localparam logic [4:0] OP_ADD_U  = 5'b00001;
   localparam logic [4:0] OP_TC_SUM = 5'b00010;
   localparam logic [4:0] OP_SUB_U  = 5'b00011;

   // Scheduler FSM: idle, datapath settling, response held for the consumer
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Bit positions inside the 4-bit flag word {cout,neg,ovf,zero}
   localparam int FLAG_ZERO = 0;
   localparam int FLAG_OVF  = 1;
   localparam int FLAG_NEG  = 2;
   localparam int FLAG_COUT = 3;
   localparam int FLAG_W    = 4;

   function automatic logic [FLAG_W-1:0] pack_flags(input logic cout, input logic neg,
                                                     input logic ovf,  input logic zero);
      logic [FLAG_W-1:0] f;
      f            = '0;
      f[FLAG_COUT] = cout;
      f[FLAG_NEG]  = neg;
      f[FLAG_OVF]  = ovf;
      f[FLAG_ZERO] = zero;
      return f;
   endfunction

endpackage

// File: rtl/dpa_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (wrapping) wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides whether the grant is consumed.
module dpa_rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 any_req
);

   localparam int ID_W = $clog2(N);

   logic [ID_W:0]   pos;
   logic [ID_W-1:0] idx;
   logic            found;

   assign any_req = |req;

   // Walk the requesters starting at ptr, wrapping at N; keep the first hit.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + (ID_W+1)'(k);
         if (pos >= (ID_W+1)'(N)) begin
            pos = pos - (ID_W+1)'(N);
         end
         idx = pos[ID_W-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/dpa_req_scheduler.sv
// Round-robin shares one add/sub datapath among NUM_REQ requesters; opcode check under DPA_OPCODE_CHECK_EN.
// Latency: accept edge -> rsp_valid two clocks later; one op in flight, peak 1 op per 2 clocks.
// Backpressure: rsp_ready low holds the response and blocks every req_ready until it is taken.
module dpa_req_scheduler
   import dpa_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int OP_LEN  = 5,
   parameter int NUM_REQ = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]    req_a,
   input  logic [NUM_REQ*WIDTH-1:0]    req_b,
   input  logic [NUM_REQ*OP_LEN-1:0]   req_opcode,
   output logic [WIDTH-1:0]            dp_a,
   output logic [WIDTH-1:0]            dp_b,
   output logic [OP_LEN-1:0]           dp_opcode,
   input  logic [WIDTH-1:0]            dp_sum,
   input  logic                        dp_cout,
   input  logic                        dp_neg,
   input  logic                        dp_ovf,
   input  logic                        dp_zero,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic [WIDTH-1:0]            rsp_sum,
   output logic [FLAG_W-1:0]           rsp_flags,
   output logic                        rsp_err
);

   localparam int ID_W = $clog2(NUM_REQ);

   state_t              state_q, state_d;
   logic [ID_W-1:0]     ptr_q;
   logic [ID_W-1:0]     id_q;
   logic [ID_W-1:0]     grant_idx;
   logic [NUM_REQ-1:0]  grant;
   logic                any_req;
   logic                grant_en;
   logic                accept;
   logic [WIDTH-1:0]    sel_a;
   logic [WIDTH-1:0]    sel_b;
   logic [OP_LEN-1:0]   sel_op;

   dpa_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   // A new op may start when idle, or when the held response is being taken this cycle.
   assign grant_en  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
   assign accept    = grant_en && any_req;
   // Gated by rst_n so every output reads zero while reset is asserted.
   assign req_ready = rst_n ? (grant & {NUM_REQ{grant_en}}) : '0;

   // One-hot mux of the granted requester's slice.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_a  = req_a[i*WIDTH +: WIDTH];
            sel_b  = req_b[i*WIDTH +: WIDTH];
            sel_op = req_opcode[i*OP_LEN +: OP_LEN];
         end
      end
   end

`ifdef DPA_OPCODE_CHECK_EN
   logic sel_legal;
   logic err_q;

   assign sel_legal = (sel_op == OP_LEN'(OP_ADD_U))  ||
                      (sel_op == OP_LEN'(OP_TC_SUM)) ||
                      (sel_op == OP_LEN'(OP_SUB_U));
`endif

   // Next-state: EXEC is always one cycle; RESP waits for rsp_ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and round-robin pointer; pointer moves past the winner on every accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // Operand issue registers; they only change on accept so the datapath sees no toggling when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_a      <= '0;
         dp_b      <= '0;
         dp_opcode <= '0;
         id_q      <= '0;
`ifdef DPA_OPCODE_CHECK_EN
         err_q     <= 1'b0;
`endif
      end else if (accept) begin
         dp_a <= sel_a;
         dp_b <= sel_b;
         id_q <= grant_idx;
`ifdef DPA_OPCODE_CHECK_EN
         if (sel_legal) begin
            dp_opcode <= sel_op;
         end
         err_q <= !sel_legal;
`else
         dp_opcode <= sel_op;
`endif
      end
   end

   // Response capture at the end of EXEC; held untouched through RESP until handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_flags <= '0;
`ifdef DPA_OPCODE_CHECK_EN
         rsp_err   <= 1'b0;
`endif
      end else begin
         rsp_valid <= (state_d == ST_RESP);
         if (state_q == ST_EXEC) begin
            rsp_id <= id_q;
`ifdef DPA_OPCODE_CHECK_EN
            rsp_sum   <= err_q ? '0 : dp_sum;
            rsp_flags <= err_q ? '0 : pack_flags(dp_cout, dp_neg, dp_ovf, dp_zero);
            rsp_err   <= err_q;
`else
            rsp_sum   <= dp_sum;
            rsp_flags <= pack_flags(dp_cout, dp_neg, dp_ovf, dp_zero);
`endif
         end
      end
   end

`ifndef DPA_OPCODE_CHECK_EN
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dpa_req_scheduler.sv
// Bench for dpa_req_scheduler with a behavioural datapath stub and a transaction-level reference model.
// Latency: model expects rsp_valid two clocks after each accept edge.
// Backpressure: random rsp_ready stalls; requesters hold their slice until granted.
module tb_dpa_req_scheduler;
   import dpa_pkg::*;

   localparam int W   = 32;
   localparam int OPL = 5;
   localparam int NR  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*W-1:0]   req_a;
   logic [NR*W-1:0]   req_b;
   logic [NR*OPL-1:0] req_opcode;
   logic [W-1:0]      dp_a, dp_b, dp_sum;
   logic [OPL-1:0]    dp_opcode;
   logic              dp_cout, dp_neg, dp_ovf, dp_zero;
   logic              rsp_valid, rsp_ready;
   logic [1:0]        rsp_id;
   logic [W-1:0]      rsp_sum;
   logic [3:0]        rsp_flags;
   logic              rsp_err;

   int n_cmp = 0;
   int n_bad = 0;

   dpa_req_scheduler #(.WIDTH(W), .OP_LEN(OPL), .NUM_REQ(NR)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
      .dp_a(dp_a), .dp_b(dp_b), .dp_opcode(dp_opcode),
      .dp_sum(dp_sum), .dp_cout(dp_cout), .dp_neg(dp_neg), .dp_ovf(dp_ovf), .dp_zero(dp_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
   );

   // Datapath stub: returns {cout,neg,ovf,zero,sum}
   function automatic logic [35:0] dp_fn(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      logic [32:0] t;
      logic [31:0] s;
      logic        c, v;
      t = '0; s = '0; c = 1'b0; v = 1'b0;
      case (op)
         OP_ADD_U: begin
            t = {1'b0, a} + {1'b0, b};
            s = t[31:0]; c = t[32];
            v = (a[31] == b[31]) && (s[31] != a[31]);
         end
         OP_SUB_U: begin
            t = {1'b0, a} + {1'b0, ~b} + 33'd1;
            s = t[31:0]; c = t[32];
            v = (a[31] != b[31]) && (s[31] != a[31]);
         end
         OP_TC_SUM: s = 32'd0 - (a + b);
         default:   s = a ^ b;
      endcase
      return {c, s[31], v, (s == 32'd0), s};
   endfunction

   assign {dp_cout, dp_neg, dp_ovf, dp_zero, dp_sum} = dp_fn(dp_a, dp_b, dp_opcode);

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [4:0] op);
      return (op == OP_ADD_U) || (op == OP_TC_SUM) || (op == OP_SUB_U);
   endfunction

   // ---------------- reference model: one op in flight, response 2 clocks after accept
   bit          m_busy;
   int          m_cnt;
   int          m_ptr;
   int          m_id;
   logic [31:0] m_sum;
   logic [3:0]  m_flags;
   logic        m_err;
   logic [31:0] m_dpa, m_dpb;
   logic [4:0]  m_dpop;

   always @(negedge clk) begin : model_cmp
      logic        exp_valid;
      logic [3:0]  exp_rdy;
      int          g;
      logic [35:0] r;
      logic [31:0] a, b;
      logic [4:0]  op;
      if (!rst_n) begin
         m_busy = 0; m_cnt = 0; m_ptr = 0; m_id = 0;
         m_dpa = '0; m_dpb = '0; m_dpop = '0;
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_sum",   rsp_sum, 0);
         chk("rst_rsp_flags", rsp_flags, 0);
         chk("rst_rsp_id",    rsp_id, 0);
         chk("rst_rsp_err",   rsp_err, 0);
         chk("rst_dp_a",      dp_a, 0);
         chk("rst_dp_b",      dp_b, 0);
         chk("rst_dp_opcode", dp_opcode, 0);
      end else begin
         if (m_busy) m_cnt++;
         exp_valid = m_busy && (m_cnt >= 2);
         exp_rdy   = '0;
         g         = -1;
         if (!m_busy || (exp_valid && rsp_ready)) begin
            for (int k = 0; k < NR; k++) begin
               if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
         end
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", req_ready, exp_rdy);
         chk("rsp_valid", rsp_valid, exp_valid);
         chk("dp_a", dp_a, m_dpa);
         chk("dp_b", dp_b, m_dpb);
         chk("dp_opcode", dp_opcode, m_dpop);
         if (exp_valid) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_sum", rsp_sum, m_sum);
            chk("rsp_flags", rsp_flags, m_flags);
            chk("rsp_err", rsp_err, m_err);
         end
         if (exp_valid && rsp_ready) m_busy = 0;
         if (g >= 0) begin
            a  = req_a[g*W +: W];
            b  = req_b[g*W +: W];
            op = req_opcode[g*OPL +: OPL];
            m_busy = 1; m_cnt = 0; m_ptr = (g + 1) % NR; m_id = g;
            m_dpa = a; m_dpb = b;
`ifdef DPA_OPCODE_CHECK_EN
            if (!legal(op)) begin
               m_sum = '0; m_flags = '0; m_err = 1'b1;
            end else begin
               m_dpop = op; r = dp_fn(a, b, op);
               m_sum = r[31:0]; m_flags = r[35:32]; m_err = 1'b0;
            end
`else
            m_dpop = op; r = dp_fn(a, b, op);
            m_sum = r[31:0]; m_flags = r[35:32]; m_err = 1'b0;
`endif
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      req_a[i*W +: W]          = a;
      req_b[i*W +: W]          = b;
      req_opcode[i*OPL +: OPL] = op;
      req_valid[i]             = 1'b1;
   endtask

   task automatic hold_until_grant(input int i);
      bit ok;
      ok = 0;
      for (int t = 0; t < 30 && !ok; t++) begin
         @(negedge clk);
         if (req_ready[i]) ok = 1;
      end
      chk($sformatf("grant_wait_req%0d", i), ok, 1);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_rsp();
      bit ok;
      ok = 0;
      for (int t = 0; t < 30 && !ok; t++) begin
         @(negedge clk);
         if (rsp_valid) ok = 1;
      end
      chk("rsp_wait", ok, 1);
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [4:0] rand_op();
      case ($urandom_range(0, 9))
         0:       return 5'b11111;
         1:       return 5'($urandom_range(0, 31));
         default: return 5'($urandom_range(1, 3));
      endcase
   endfunction

   task automatic run_random(input int cycles);
      logic [NR-1:0] hs;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < NR; i++) begin
            if (hs[i] || !req_valid[i]) begin
               if ($urandom_range(0, 2) != 0) set_req(i, rand_word(), rand_word(), rand_op());
               else req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // ---------------- directed scenarios followed by random traffic
   initial begin
      int got;
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_opcode = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_dp_a", dp_a, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single ADD_U from requester 0: same-cycle ready, response two clocks later
      rsp_ready = 1'b1;
      set_req(0, 32'd7, 32'd2, OP_ADD_U);
      #1 chk("t1_ready_same_cycle", req_ready, 4'b0001);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk); chk("t1_exec_no_rsp", rsp_valid, 0);
      @(negedge clk);
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_id", rsp_id, 0);
      chk("t1_rsp_sum", rsp_sum, 32'd9);
      chk("t1_rsp_flags", rsp_flags, 4'b0000);
      @(posedge clk); #1;

      // Signed-looking operands and TC_SUM (also moves the pointer back to 0)
      set_req(2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, OP_ADD_U);
      hold_until_grant(2);
      wait_rsp();
      chk("t3_add_sum", rsp_sum, 32'hFFFF_FFF7);
      chk("t3_add_cout", rsp_flags[FLAG_COUT], 1);
      chk("t3_add_neg", rsp_flags[FLAG_NEG], 1);
      @(posedge clk); #1;
      set_req(3, 32'd7, 32'd2, OP_TC_SUM);
      hold_until_grant(3);
      wait_rsp();
      chk("t3_tc_sum", rsp_sum, 32'hFFFF_FFF7);
      chk("t3_tc_id", rsp_id, 3);
      @(posedge clk); #1;

      // All four requesters at once: grants 0,1,2,3
      for (int i = 0; i < NR; i++) set_req(i, 32'd7, 32'd2, OP_SUB_U);
      for (int n = 0; n < NR; n++) begin
         got = -1;
         for (int t = 0; t < 30 && got < 0; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
               chk("t2_rsp_sum", rsp_sum, 32'd5);
               chk("t2_rsp_cout", rsp_flags[FLAG_COUT], 1);
            end
            for (int i = 0; i < NR; i++) if (req_ready[i]) got = i;
         end
         chk("t2_grant_order", got, n);
         @(posedge clk); #1;
         if (got >= 0) req_valid[got] = 1'b0;
      end
      wait_rsp();
      chk("t2_last_id", rsp_id, 3);
      chk("t2_last_sum", rsp_sum, 32'd5);
      @(posedge clk); #1;

      // Response stall with requester 1 pending
      rsp_ready = 1'b0;
      set_req(0, 32'd1, 32'd1, OP_ADD_U);
      hold_until_grant(0);
      set_req(1, 32'd3, 32'd4, OP_ADD_U);
      wait_rsp();
      for (int t = 0; t < 5; t++) begin
         chk("t4_stall_valid", rsp_valid, 1);
         chk("t4_stall_sum", rsp_sum, 32'd2);
         chk("t4_stall_id", rsp_id, 0);
         chk("t4_stall_ready", req_ready, 4'b0000);
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      #1 chk("t4_req1_granted", req_ready, 4'b0010);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_rsp();
      chk("t4_rsp_id", rsp_id, 1);
      chk("t4_rsp_sum", rsp_sum, 32'd7);
      @(posedge clk); #1;

      // Asynchronous reset during EXEC drops the op and resets the pointer
      set_req(1, 32'd10, 32'd20, OP_ADD_U);
      hold_until_grant(1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_dp_a", dp_a, 0);
      chk("t5_dp_b", dp_b, 0);
      chk("t5_rsp_sum", rsp_sum, 0);
      chk("t5_req_ready", req_ready, 0);
      set_req(2, 32'd100, 32'd1, OP_ADD_U);
      set_req(0, 32'd200, 32'd1, OP_ADD_U);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("t5_req0_first", req_ready, 4'b0001);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_rsp();
      chk("t5_first_id", rsp_id, 0);
      chk("t5_first_sum", rsp_sum, 32'd201);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      wait_rsp();
      chk("t5_second_id", rsp_id, 2);
      chk("t5_second_sum", rsp_sum, 32'd101);
      @(posedge clk); #1;

      // Illegal opcode
      set_req(0, 32'd5, 32'd6, 5'b11111);
      hold_until_grant(0);
      wait_rsp();
`ifdef DPA_OPCODE_CHECK_EN
      chk("t6_err", rsp_err, 1);
      chk("t6_sum", rsp_sum, 0);
      chk("t6_dp_opcode_kept", dp_opcode, OP_ADD_U);
`else
      chk("t6_err", rsp_err, 0);
      chk("t6_dp_opcode", dp_opcode, 5'b11111);
`endif
      @(posedge clk); #1;

      run_random(1500);

      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
